// File: rtl/mult_iter_unit.sv
// Iterative shift-add 32x32 multiplier for MULT/MULTU with a begin/end/accept handshake.
// Retires STEP_BITS multiplier bits per cycle; the sign is applied once, at completion.
module mult_iter_unit #(
    parameter int unsigned STEP_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_begin,
    input  logic        mult_signed,
    input  logic [31:0] mult_op1,
    input  logic [31:0] mult_op2,
    input  logic        mult_accept,
    output logic [63:0] product,
    output logic        mult_end,
    output logic        mult_busy
);

    localparam int unsigned N    = 32 / STEP_BITS;
    localparam int unsigned CntW = 6;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    if (!(STEP_BITS == 1 || STEP_BITS == 2 || STEP_BITS == 4)) begin : gen_step_check
        $error("mult_iter_unit: STEP_BITS must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [63:0]     mcand_q, mcand_d;
    logic [31:0]     mplier_q, mplier_d;
    logic [63:0]     acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic [63:0]     product_q, product_d;

    logic [31:0]          op1_abs, op2_abs;
    logic [STEP_BITS-1:0] digit;
    logic [63:0]          partial;
    logic [63:0]          acc_sum;

    // -2^31 negates to itself, which is already the correct unsigned magnitude.
    assign op1_abs = (mult_signed && mult_op1[31]) ? (~mult_op1 + 32'd1) : mult_op1;
    assign op2_abs = (mult_signed && mult_op2[31]) ? (~mult_op2 + 32'd1) : mult_op2;

    assign digit   = mplier_q[STEP_BITS-1:0];
    assign partial = mcand_q * 64'(digit);
    assign acc_sum = acc_q + partial;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                if (mult_begin) begin
                    mcand_d  = {32'd0, op1_abs};
                    mplier_d = op2_abs;
                    neg_d    = mult_signed & (mult_op1[31] ^ mult_op2[31]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                // A dropped request aborts; the previous product is left untouched.
                if (!mult_begin) begin
                    state_d = StIdle;
                end else begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << STEP_BITS;
                    mplier_d = mplier_q >> STEP_BITS;
                    cnt_d    = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        product_d = neg_q ? (~acc_sum + 64'd1) : acc_sum;
                        state_d   = StDone;
                    end
                end
            end
            StDone: begin
                if (mult_accept || !mult_begin) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign product   = product_q;
    assign mult_end  = (state_q == StDone);
    assign mult_busy = (state_q == StBusy);

endmodule

// File: tb/tb_mult_iter_unit.sv
// Bench for mult_iter_unit: one instance per legal STEP_BITS, table vectors, handshake
// sequences and random operands against an arithmetic reference model.
module tb_mult_iter_unit;

    logic        clk;
    logic        reset;
    logic        begin_s   [3];
    logic        sgn_s     [3];
    logic [31:0] op1_s     [3];
    logic [31:0] op2_s     [3];
    logic        accept_s  [3];
    logic [63:0] product_s [3];
    logic        end_s     [3];
    logic        busy_s    [3];

    int checks = 0;
    int errors = 0;
    int nlat [3] = '{33, 17, 9};
    int nbusy[3] = '{32, 16, 8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mult_iter_unit #(.STEP_BITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .mult_begin(begin_s[0]), .mult_signed(sgn_s[0]),
        .mult_op1(op1_s[0]), .mult_op2(op2_s[0]), .mult_accept(accept_s[0]),
        .product(product_s[0]), .mult_end(end_s[0]), .mult_busy(busy_s[0])
    );
    mult_iter_unit #(.STEP_BITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .mult_begin(begin_s[1]), .mult_signed(sgn_s[1]),
        .mult_op1(op1_s[1]), .mult_op2(op2_s[1]), .mult_accept(accept_s[1]),
        .product(product_s[1]), .mult_end(end_s[1]), .mult_busy(busy_s[1])
    );
    mult_iter_unit #(.STEP_BITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .mult_begin(begin_s[2]), .mult_signed(sgn_s[2]),
        .mult_op1(op1_s[2]), .mult_op2(op2_s[2]), .mult_accept(accept_s[2]),
        .product(product_s[2]), .mult_end(end_s[2]), .mult_busy(busy_s[2])
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one multiply, scramble operands mid-flight, wait for mult_end, then accept.
    task automatic run_op(input int k, input logic s, input logic [31:0] a,
                          input logic [31:0] b, output logic [63:0] p, output int lat);
        sgn_s[k]    = s;
        op1_s[k]    = a;
        op2_s[k]    = b;
        begin_s[k]  = 1'b1;
        tick();
        lat = 1;
        op1_s[k] = $urandom;
        op2_s[k] = $urandom;
        sgn_s[k] = ~s;
        while (!end_s[k] && lat < 60) begin
            tick();
            lat++;
        end
        p = product_s[k];
        accept_s[k] = 1'b1;
        begin_s[k]  = 1'b0;
        tick();
        accept_s[k] = 1'b0;
    endtask

    initial begin
        logic [63:0] p;
        int          lat;
        int          low;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;

        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            begin_s[k] = 1'b0; sgn_s[k] = 1'b0; op1_s[k] = '0; op2_s[k] = '0;
            accept_s[k] = 1'b0;
        end
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_product[%0d]", k), product_s[k], 64'd0);
            chk($sformatf("reset_end[%0d]", k), 64'(end_s[k]), 64'd0);
            chk($sformatf("reset_busy[%0d]", k), 64'(busy_s[k]), 64'd0);
        end

        // Signed 7 x -3 with exact per-cycle handshake timing; stray accept in BUSY ignored.
        sgn_s[0] = 1'b1; op1_s[0] = 32'd7; op2_s[0] = 32'hFFFF_FFFD; begin_s[0] = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            tick();
            accept_s[0] = (c == 5);
            chk($sformatf("t1_busy_c%0d", c), 64'(busy_s[0]), 64'(c <= 32));
            chk($sformatf("t1_end_c%0d", c), 64'(end_s[0]), 64'(c == 33));
        end
        chk("t1_product", product_s[0], 64'hFFFF_FFFF_FFFF_FFEB);
        tick();
        chk("t1_hold_done", 64'(end_s[0]), 64'd1);
        accept_s[0] = 1'b1;
        begin_s[0]  = 1'b0;
        tick();
        accept_s[0] = 1'b0;
        chk("t1_end_after_accept", 64'(end_s[0]), 64'd0);
        chk("t1_product_kept", product_s[0], 64'hFFFF_FFFF_FFFF_FFEB);

        // Abort mid-BUSY: request dropped in cycle 10.
        sgn_s[0] = 1'b0; op1_s[0] = 32'h1234; op2_s[0] = 32'h10; begin_s[0] = 1'b1;
        for (int c = 1; c <= 10; c++) tick();
        chk("abort_busy_c10", 64'(busy_s[0]), 64'd1);
        begin_s[0] = 1'b0;
        tick();
        chk("abort_busy_c11", 64'(busy_s[0]), 64'd0);
        for (int c = 0; c < 40; c++) begin
            if (end_s[0]) chk("abort_end_asserted", 64'(end_s[0]), 64'd0);
            tick();
        end
        chk("abort_product_unchanged", product_s[0], 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(0, 1'b0, 32'd3, 32'd5, p, lat);
        chk("reissue_product", p, 64'd15);
        chk("reissue_latency", 64'(lat), 64'd33);

        // Table vectors on every STEP_BITS instance.
        vecs[0] = '{1'b1, 32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[4] = '{1'b1, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'd1,         64'hFFFF_FFFF_8000_0000};
        vecs[6] = '{1'b0, 32'd0,          32'hDEAD_BEEF, 64'd0};
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 7; i++) begin
                run_op(k, vecs[i].sgn, vecs[i].a, vecs[i].b, p, lat);
                chk($sformatf("vec%0d_s%0d_product", i, k), p, vecs[i].exp);
                chk($sformatf("vec%0d_s%0d_latency", i, k), 64'(lat), 64'(nlat[k]));
            end
        end

        // Back-to-back with mult_begin held; accept in the first DONE cycle.
        sgn_s[0] = 1'b0; op1_s[0] = 32'd2; op2_s[0] = 32'd3; begin_s[0] = 1'b1;
        lat = 0;
        while (!end_s[0] && lat < 60) begin
            tick();
            lat++;
        end
        chk("b2b_first_product", product_s[0], 64'd6);
        op1_s[0] = 32'd4; op2_s[0] = 32'd5; accept_s[0] = 1'b1;
        tick();
        accept_s[0] = 1'b0;
        low = 1;
        while (!end_s[0] && low < 60) begin
            tick();
            if (!end_s[0]) low++;
        end
        chk("b2b_end_low_cycles", 64'(low), 64'(1 + nbusy[0]));
        chk("b2b_second_product", product_s[0], 64'd20);
        accept_s[0] = 1'b1; begin_s[0] = 1'b0;
        tick();
        accept_s[0] = 1'b0;

        // Synchronous reset in cycle 15 of a BUSY run.
        sgn_s[0] = 1'b1; op1_s[0] = 32'd99; op2_s[0] = 32'd101; begin_s[0] = 1'b1;
        for (int c = 1; c <= 15; c++) tick();
        reset = 1'b1; begin_s[0] = 1'b0;
        tick();
        reset = 1'b0;
        chk("rst_mid_product", product_s[0], 64'd0);
        chk("rst_mid_end", 64'(end_s[0]), 64'd0);
        chk("rst_mid_busy", 64'(busy_s[0]), 64'd0);
        run_op(0, 1'b1, 32'hFFFF_FFF6, 32'd12, p, lat);
        chk("rst_after_product", p, 64'hFFFF_FFFF_FFFF_FF88);
        chk("rst_after_latency", 64'(lat), 64'd33);

        // Random operands against the reference model.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 1000; i++) begin
                s = 1'($urandom);
                a = $urandom;
                b = $urandom;
                if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'd0;
                run_op(k, s, a, b, p, lat);
                chk($sformatf("rand_s%0d_%0d_%h_%h_%b", k, i, a, b, s), p, ref_mul(s, a, b));
                if (lat != nlat[k]) chk($sformatf("rand_s%0d_%0d_latency", k, i), 64'(lat), 64'(nlat[k]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
